// File: rtl/ha_pkg.sv
// rtl/ha_pkg.sv - shared types and constants for the half-adder exerciser
package ha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef logic [1:0] vec_t;

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = 8'hFF;

endpackage

// File: rtl/ha_ref_model.sv
// rtl/ha_ref_model.sv - golden half-adder response used for comparison
module ha_ref_model (
  input  logic a,
  input  logic b,
  output logic exp_sum,
  output logic exp_carry
);

  assign exp_sum   = a ^ b;
  assign exp_carry = a & b;

endmodule

// File: rtl/ha_exerciser.sv
// rtl/ha_exerciser.sv - drives the four half-adder input vectors, checks
// responses and reports error count, first failing vector and pass/done.
module ha_exerciser
  import ha_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             a_o,
  output logic             b_o,
  input  logic             sum_i,
  input  logic             carry_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_vec
);

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_e           state_q, state_d;
  vec_t             vec_q, vec_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [1:0]       ffvec_q, ffvec_d;

  logic exp_sum, exp_carry, mismatch;

  ha_ref_model u_ref (
    .a         (a_q),
    .b         (b_q),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry)
  );

  assign mismatch = (sum_i != exp_sum) || (carry_i != exp_carry);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = 2'b00;
          pass_d  = 1'b0;
          vec_d   = 2'b00;
          pcnt_d  = 8'd0;
          wcnt_d  = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = 4'd0;
          state_d = ST_CHECK;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_d = (err_q == CNT_SAT) ? err_q : err_q + 8'd1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = {a_q, b_q};
          end
        end
        if (vec_q != 2'b11) begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          state_d    = ST_WAIT;
        end else if (pcnt_q < PASS_LAST) begin
          vec_d   = 2'b00;
          pcnt_d  = pcnt_q + 8'd1;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = ST_WAIT;
        end else begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort discards anything decided above, including a same-cycle comparison
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      vec_d   = vec_q;
      pcnt_d  = pcnt_q;
      wcnt_d  = 4'd0;
      a_d     = 1'b0;
      b_d     = 1'b0;
      pass_d  = 1'b0;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'b00;
      pcnt_q  <= 8'd0;
      wcnt_q  <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= 2'b00;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign a_o            = a_q;
  assign b_o            = b_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule

// File: doc/ha_exerciser.md
HA_EXERCISER -- requirements
Module: ha_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the cycles each vector is held before its response is sampled (legal 1..15).
REQ-002 Parameter PASSES, default 1, SHALL set how many times the 4-vector sequence repeats per run (legal 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a run; it is sampled only in IDLE.
REQ-006 abort  input  1  SHALL terminate a run immediately with no done pulse.
REQ-007 a_o, b_o  output  1 each  SHALL be registered drives to the half-adder A and B.
REQ-008 sum_i, carry_i  input  1 each  SHALL be the half-adder responses under test.
REQ-009 busy  output  1  SHALL be high in every state other than IDLE.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle when a run completes.
REQ-011 pass  output  1  SHALL be high when the last completed run had err_count == 0; it holds until the next start.
REQ-012 err_count  output  8  SHALL count mismatches in the current or last run.
REQ-013 first_fail_vld  output  1  SHALL go high once the first mismatch of a run is captured.
REQ-014 first_fail_vec  output  2  SHALL hold {A,B} of the first mismatching vector.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, CHECK and DONE.
REQ-016 IDLE with start=1 SHALL clear err_count, first_fail_vld, first_fail_vec and pass.
  - It then loads vector index 0 and pass counter 0, and moves to WAIT.
REQ-017 Vector index v (2 bits) SHALL drive a_o=v[1], b_o=v[0], registered on entry to WAIT; the sequence is 00, 01, 10, 11.
REQ-018 WAIT SHALL last exactly SETTLE_CYCLES cycles, then move to CHECK.
REQ-019 CHECK SHALL last one cycle and compare sum_i against a_o^b_o and carry_i against a_o&b_o.
  - A mismatch on either or both bits SHALL count as one error.
REQ-020 Leaving CHECK SHALL go as follows:
  - v<3: v+1, back to WAIT.
  - v==3 and pass counter < PASSES-1: v=0, pass counter+1, back to WAIT.
  - Otherwise: DONE.
REQ-021 DONE SHALL last one cycle: done=1, pass updated, then IDLE.
REQ-022 Latency: with start sampled at edge t0, the CHECK cycles SHALL be t0+k*(SETTLE_CYCLES+1) for k=1..4*PASSES, and done SHALL be high in cycle t0+4*PASSES*(SETTLE_CYCLES+1)+1.
REQ-023 err_count SHALL saturate at 255 and never wrap.
REQ-024 first_fail_vec/first_fail_vld SHALL capture only the first mismatch per run; later mismatches SHALL NOT alter them.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort in any non-IDLE state SHALL go to IDLE next cycle with a_o=b_o=0 and no done.
  - err_count and first_fail_* SHALL hold; pass SHALL be 0.
REQ-027 abort SHALL take priority over a CHECK comparison in the same cycle; that comparison is not counted.
REQ-028 abort and start both high in IDLE SHALL be ignored; abort wins.
REQ-029 a_o/b_o SHALL return to 0 on entry to IDLE after DONE.

Reset
REQ-030 rst=1 SHALL force, at the next edge: state IDLE, a_o=b_o=0, busy=0, done=0, pass=0, err_count=0, first_fail_vld=0, first_fail_vec=0.
REQ-031 rst SHALL take priority over start and abort, including mid-run; no done is emitted.

Structure
REQ-032 Package ha_pkg SHALL hold the state enum typedef, the 2-bit vector typedef, and the count-width and saturation constants.
REQ-033 The expected-response logic SHALL be a combinational sub-module ha_ref_model with inputs a, b and outputs exp_sum, exp_carry.

Verification
REQ-034 Golden h_a connected, defaults, start at t0:
  - done at t0+13; pass=1, err_count=0, first_fail_vld=0.
REQ-035 Faulty carry stuck at 0:
  - pass=0, err_count=1, first_fail_vec=2'b11.
REQ-036 Faulty sum inverted, PASSES=2:
  - err_count=8, first_fail_vec=2'b00.
REQ-037 Faulty sum inverted, PASSES=100:
  - err_count=255 (saturated), done at t0+1201.
REQ-038 Golden DUT, abort at t0+5:
  - IDLE at t0+6; a_o=b_o=0, no done, pass=0.
  - A start pulse at t0+2 is ignored.
REQ-039 Golden DUT, rst at t0+7:
  - all outputs at reset values next cycle.
  - A fresh start then completes normally, with done 13 cycles later.
